// File: rtl/pc_gen_pkg.sv
// Shared fetch-stage constants and the fetch controller state type.
package pc_gen_pkg;

    // Control-line polarities shared across the pipeline.
    localparam logic RST_ENA   = 1'b1;
    localparam logic CHIP_ENA  = 1'b1;
    localparam logic CHIP_DISA = 1'b0;

    // Controller state; values chosen so the state bit doubles as the chip enable.
    typedef enum logic {
        WARMUP = 1'b0,
        RUN    = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/pc_redirect_buf.sv
// One-entry redirect buffer: valid flag plus target, with set/overwrite and clear.
module pc_redirect_buf
    import pc_gen_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             set,
    input  logic             clr,
    input  logic [WIDTH-1:0] target_in,
    output logic             valid,
    output logic [WIDTH-1:0] target
);

    // Set captures (or overwrites) the target; clear drops the valid flag.
    always_ff @(posedge clk) begin
        if (rst == RST_ENA) begin
            valid  <= 1'b0;
            target <= '0;
        end else if (set) begin
            valid  <= 1'b1;
            target <= target_in;
        end else if (clr) begin
            valid  <= 1'b0;
        end
    end

endmodule

// File: rtl/pc_gen.sv
// Fetch-stage program counter generator with stall, branch and flush redirect.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH   = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
    parameter int unsigned           INST_BYTES   = 4,
    parameter int unsigned           ALIGN_BITS   = $clog2(INST_BYTES)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  branch_flag,
    input  logic [ADDR_WIDTH-1:0] branch_target,
    input  logic                  flush,
    input  logic [ADDR_WIDTH-1:0] new_pc,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic                  ce,
    output logic                  pc_misaligned,
    output logic                  redirect_pending
);

    localparam logic [ADDR_WIDTH-1:0] PC_INC     = ADDR_WIDTH'(INST_BYTES);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'((64'd1 << ALIGN_BITS) - 64'd1);

    fetch_state_e          state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic                  buf_set, buf_clr, buf_valid;
    logic [ADDR_WIDTH-1:0] buf_target;

    pc_redirect_buf #(
        .WIDTH(ADDR_WIDTH)
    ) u_redirect_buf (
        .clk      (clk),
        .rst      (rst),
        .set      (buf_set),
        .clr      (buf_clr),
        .target_in(branch_target),
        .valid    (buf_valid),
        .target   (buf_target)
    );

    // State and pc registers; reset parks the controller in warm-up at the reset vector.
    always_ff @(posedge clk) begin
        if (rst == RST_ENA) begin
            state_q <= WARMUP;
            pc_q    <= RESET_VECTOR;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // Next-state and next-pc priority mux: flush > stall > branch > buffered > increment.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        buf_set = 1'b0;
        buf_clr = 1'b0;
        case (state_q)
            WARMUP: begin
                state_d = RUN;
            end
            RUN: begin
                if (flush) begin
                    pc_d    = new_pc;
                    buf_clr = 1'b1;
                end else if (stall) begin
                    buf_set = branch_flag;
                end else if (branch_flag) begin
                    pc_d    = branch_target;
                    buf_clr = 1'b1;
                end else if (buf_valid) begin
                    pc_d    = buf_target;
                    buf_clr = 1'b1;
                end else begin
                    pc_d    = pc_q + PC_INC;
                end
            end
        endcase
    end

    assign ce               = (state_q == RUN) ? CHIP_ENA : CHIP_DISA;
    assign pc               = pc_q;
    assign redirect_pending = buf_valid;
    assign pc_misaligned    = (ce == CHIP_ENA) && ((pc_q & ALIGN_MASK) != '0);

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
Parametrised program-counter generator, the fetch-stage front end of the MIPS pipeline. Drives the instruction-memory address and chip enable. Beyond sequential increment it supports pipeline stall, branch/jump redirect, and exception/flush redirect. A one-entry pending-redirect buffer ensures a branch resolved during a stall is not lost.

Parameters:
ADDR_WIDTH, 32, width of pc and all target buses
RESET_VECTOR, 32'h00000000, pc value presented on the first enabled fetch after reset
INST_BYTES, 4, pc increment per sequential fetch; power of two, 1..8
ALIGN_BITS, $clog2(INST_BYTES), low pc bits that must be zero for an aligned fetch

Ports:
clk  in  1  system clock; all state updates on posedge
rst  in  1  synchronous reset, active-high (`RstEna)
stall  in  1  fetch stall from pipeline control; pc holds while high
branch_flag  in  1  branch/jump taken, single-cycle pulse from decode
branch_target  in  ADDR_WIDTH  target address qualified by branch_flag
flush  in  1  exception/eret flush from control, highest non-reset priority
new_pc  in  ADDR_WIDTH  redirect address qualified by flush
pc  out  ADDR_WIDTH  instruction fetch address (registered)
ce  out  1  instruction memory chip enable (registered; `ChipEna / `ChipDisa)
pc_misaligned  out  1  pc[ALIGN_BITS-1:0] != 0 while ce is `ChipEna (combinational from registers)
redirect_pending  out  1  a branch target is buffered awaiting stall release (registered)

Behaviour:
- Reset (rst=1 at posedge): ce<=`ChipDisa, pc<=RESET_VECTOR, redirect_pending<=0, buffered target<=0. Overrides all other inputs. Reset asserted mid-operation discards any pending redirect.
- Warm-up: first posedge with rst=0 while ce=`ChipDisa: ce<=`ChipEna, pc stays RESET_VECTOR. All other inputs ignored this cycle. First fetch address is therefore RESET_VECTOR, one cycle after reset release.
- Run (ce=`ChipEna), priority order per posedge:
  1. flush=1: pc<=new_pc; redirect_pending<=0. Ignores stall and branch_flag.
  2. stall=1: pc holds. If branch_flag=1: redirect_pending<=1, buffered target<=branch_target (latest wins if already pending).
  3. branch_flag=1: pc<=branch_target; redirect_pending<=0. Fresh branch supersedes any buffered one.
  4. redirect_pending=1: pc<=buffered target; redirect_pending<=0.
  5. Otherwise: pc<=pc+INST_BYTES, modulo 2^ADDR_WIDTH (wraps all-ones region to 0, no flag).
- Latency: redirect visible on pc the cycle after the qualifying posedge. Buffered redirect is applied on the first non-stalled posedge.
- No alignment correction; misaligned targets propagate to pc and raise pc_misaligned for exception logic. pc_misaligned=0 while ce=`ChipDisa.
- ce never deasserts after warm-up except via rst.
- Implementation: a two-state controller (WARMUP, RUN) encoded by ce itself, plus one next-pc priority mux.

Decomposition:
- Shared include define.v holds `RstEna, `ChipEna, `ChipDisa. The parametrised width replaces the fixed `InstAddrBus for this block.
- One sub-module: pc_redirect_buf (1-entry valid+target register with set/clear/overwrite), reusable for a later delay-slot/BTB stage.
- The next-pc mux stays inline in pc_gen.

Test Plan:
- Reset release: rst=1 for 3 cycles, then 0 -> ce=0,pc=0 during reset; cycle1 ce=1,pc=0; cycle2 pc=4; cycle3 pc=8.
- Branch: at pc=0x10 pulse branch_flag, branch_target=0x100 -> next pc=0x100, then 0x104.
- Branch under stall: stall=1 at pc=0x20, pulse branch_flag target=0x200 -> pc holds 0x20, redirect_pending=1; drop stall two cycles later -> pc=0x200, pending=0, then 0x204.
- Priority: same cycle flush=1,new_pc=0x80000180, stall=1, branch_flag=1,target=0x300 -> pc=0x80000180, pending=0. Separately pending set, then flush -> pending cleared, pc=new_pc.
- Wrap/misalign: ADDR_WIDTH=32, force pc=0xFFFFFFFC via branch -> next pc=0x00000000. Branch to 0x102 -> pc_misaligned=1, next pc=0x106 with pc_misaligned=1.
- Reset mid-operation: pending=1, pc=0x400, assert rst -> next posedge ce=0, pc=RESET_VECTOR, pending=0. Repeat with RESET_VECTOR=32'hBFC00000, INST_BYTES=4 -> first fetch 0xBFC00000.
